// File: rtl/range_stats_tracker_if.sv
// Sample/readout bundle for range_stats_tracker.
// master: the sample source / readout consumer; slave: the tracker itself.
// The sum signal exists only when RANGE_SUM_EN is defined.
interface range_stats_tracker_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]       data_in;
    logic                   data_valid;
    logic                   go;
    logic                   finish;
    logic [WIDTH-1:0]       range;
    logic [WIDTH-1:0]       min_out;
    logic [WIDTH-1:0]       max_out;
    logic [CNT_W-1:0]       count;
    logic                   result_valid;
    logic                   busy;
    logic                   error;
    logic [1:0]             err_code;
`ifdef RANGE_SUM_EN
    logic [WIDTH+CNT_W-1:0] sum;
`endif

    modport master (
`ifdef RANGE_SUM_EN
        input  sum,
`endif
        output data_in, data_valid, go, finish,
        input  range, min_out, max_out, count, result_valid, busy, error, err_code
    );

    modport slave (
`ifdef RANGE_SUM_EN
        output sum,
`endif
        input  data_in, data_valid, go, finish,
        output range, min_out, max_out, count, result_valid, busy, error, err_code
    );
endinterface

// File: rtl/range_stats_tracker.sv
// Framed-stream statistics: min, max, range and saturating sample count over the
// qualified samples between go and finish, latched into holding registers when a
// non-empty frame closes. Signed or unsigned compare selected by SIGNED.
// Optional feature: define RANGE_SUM_EN to add the latched wrap-around sample sum.
module range_stats_tracker #(
    parameter int WIDTH  = 16,
    parameter int CNT_W  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    range_stats_tracker_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECEIVING = 2'd1,
        DONE      = 2'd2,
        ERROR     = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Running (in-frame) statistics
    logic [WIDTH-1:0] run_min_reg, run_min_next;
    logic [WIDTH-1:0] run_max_reg, run_max_next;
    logic [CNT_W-1:0] run_cnt_reg, run_cnt_next;
    logic [CNT_W-1:0] cnt_inc;

    // Latched results of the last good frame
    logic [WIDTH-1:0] range_reg, min_reg, max_reg;
    logic [CNT_W-1:0] count_reg;
    logic [1:0]       err_code_reg, err_code_next;
    logic             latch_en;

    // Control decode
    logic open_frame;   // go without finish: start or restart a frame
    logic go_and_fin;   // illegal combination
    logic accept_run;   // in-frame sample (not the opening one)
    logic lt_min, gt_max;

    assign open_frame = bus.go & ~bus.finish;
    assign go_and_fin = bus.go & bus.finish;
    assign accept_run = (state_reg == RECEIVING) && bus.data_valid && !bus.go;

    // Strict comparators; equal samples never move a bound
    generate
        if (SIGNED) begin : g_signed_cmp
            assign lt_min = $signed(bus.data_in) < $signed(run_min_reg);
            assign gt_max = $signed(bus.data_in) > $signed(run_max_reg);
        end else begin : g_unsigned_cmp
            assign lt_min = bus.data_in < run_min_reg;
            assign gt_max = bus.data_in > run_max_reg;
        end
    endgenerate

    // Counter holds at all-ones instead of wrapping
    assign cnt_inc = (run_cnt_reg == {CNT_W{1'b1}}) ? run_cnt_reg : run_cnt_reg + 1'b1;

    // Next running min/max/count, including the sample of the current cycle
    always_comb begin
        run_min_next = run_min_reg;
        run_max_next = run_max_reg;
        run_cnt_next = run_cnt_reg;
        if (open_frame) begin
            run_min_next = bus.data_in;
            run_max_next = bus.data_in;
            run_cnt_next = bus.data_valid ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
        end else if (accept_run) begin
            if (run_cnt_reg == {CNT_W{1'b0}}) begin
                // first sample of a frame opened without data
                run_min_next = bus.data_in;
                run_max_next = bus.data_in;
            end else begin
                if (lt_min) run_min_next = bus.data_in;
                if (gt_max) run_max_next = bus.data_in;
            end
            run_cnt_next = cnt_inc;
        end
    end

    // Next state, error code and latch strobe
    always_comb begin
        state_next    = state_reg;
        err_code_next = err_code_reg;
        latch_en      = 1'b0;
        case (state_reg)
            ERROR: begin
                // go&finish and finish alone both hold ERROR with the code unchanged
                if (open_frame) begin
                    state_next    = RECEIVING;
                    err_code_next = 2'd0;
                end
            end
            RECEIVING: begin
                if (go_and_fin) begin
                    state_next    = ERROR;
                    err_code_next = 2'd1;
                end else if (open_frame) begin
                    state_next    = RECEIVING;
                    err_code_next = 2'd0;
                end else if (bus.finish) begin
                    if (run_cnt_next != {CNT_W{1'b0}}) begin
                        state_next = DONE;
                        latch_en   = 1'b1;
                    end else begin
                        state_next    = ERROR;
                        err_code_next = 2'd3;
                    end
                end
            end
            default: begin  // IDLE, DONE
                if (go_and_fin) begin
                    state_next    = ERROR;
                    err_code_next = 2'd1;
                end else if (open_frame) begin
                    state_next    = RECEIVING;
                    err_code_next = 2'd0;
                end else if (bus.finish) begin
                    state_next    = ERROR;
                    err_code_next = 2'd2;
                end
            end
        endcase
    end

    // State and error code registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            err_code_reg <= 2'd0;
        end else begin
            state_reg    <= state_next;
            err_code_reg <= err_code_next;
        end
    end

    // Running statistics registers; reset aborts any frame in progress
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_min_reg <= '0;
            run_max_reg <= '0;
            run_cnt_reg <= '0;
        end else begin
            run_min_reg <= run_min_next;
            run_max_reg <= run_max_next;
            run_cnt_reg <= run_cnt_next;
        end
    end

    // Holding registers, written only on a good frame close
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            range_reg <= '0;
            min_reg   <= '0;
            max_reg   <= '0;
            count_reg <= '0;
        end else if (latch_en) begin
            range_reg <= run_max_next - run_min_next;
            min_reg   <= run_min_next;
            max_reg   <= run_max_next;
            count_reg <= run_cnt_next;
        end
    end

`ifdef RANGE_SUM_EN
    localparam int SUM_W = WIDTH + CNT_W;

    logic [SUM_W-1:0] sample_ext;
    logic [SUM_W-1:0] run_sum_reg, run_sum_next, sum_reg;

    assign sample_ext = SIGNED ? {{CNT_W{bus.data_in[WIDTH-1]}}, bus.data_in}
                               : {{CNT_W{1'b0}}, bus.data_in};

    // Running sum follows the same acceptance rules as the count, wrapping freely
    always_comb begin
        run_sum_next = run_sum_reg;
        if (open_frame) begin
            run_sum_next = bus.data_valid ? sample_ext : {SUM_W{1'b0}};
        end else if (accept_run) begin
            run_sum_next = run_sum_reg + sample_ext;
        end
    end

    // Running and latched sum registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_sum_reg <= '0;
            sum_reg     <= '0;
        end else begin
            run_sum_reg <= run_sum_next;
            if (latch_en) sum_reg <= run_sum_next;
        end
    end

    assign bus.sum = sum_reg;
`endif

    assign bus.range        = range_reg;
    assign bus.min_out      = min_reg;
    assign bus.max_out      = max_reg;
    assign bus.count        = count_reg;
    assign bus.result_valid = (state_reg == DONE);
    assign bus.busy         = (state_reg == RECEIVING);
    assign bus.error        = (state_reg == ERROR);
    assign bus.err_code     = err_code_reg;

endmodule

// File: tb/tb_range_stats_tracker.sv
// Directed bench for range_stats_tracker (WIDTH=8, CNT_W=4): one unsigned and one
// signed instance; expected output snapshots are queued as stimulus is driven and
// compared after the edge that should produce them.
module tb_range_stats_tracker;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    range_stats_tracker_if #(.WIDTH(8), .CNT_W(4)) bus_u ();
    range_stats_tracker_if #(.WIDTH(8), .CNT_W(4)) bus_s ();

    range_stats_tracker #(.WIDTH(8), .CNT_W(4), .SIGNED(1'b0)) dut_u (
        .clock (clock),
        .reset (reset),
        .bus   (bus_u)
    );

    range_stats_tracker #(.WIDTH(8), .CNT_W(4), .SIGNED(1'b1)) dut_s (
        .clock (clock),
        .reset (reset),
        .bus   (bus_s)
    );

    typedef struct {
        string      tag;
        logic [7:0] rng;
        logic [7:0] mn;
        logic [7:0] mx;
        logic [3:0] cnt;
        logic       rv;
        logic       busy;
        logic       err;
        logic [1:0] code;
        logic [11:0] sum;
    } exp_t;

    exp_t sb_u[$];
    exp_t sb_s[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic exp_t mk(input string tag, input int rng, input int mn, input int mx,
                                input int cnt, input bit rv, input bit busy, input bit err,
                                input int code, input int sum);
        exp_t e;
        e.tag  = tag;
        e.rng  = rng[7:0];
        e.mn   = mn[7:0];
        e.mx   = mx[7:0];
        e.cnt  = cnt[3:0];
        e.rv   = rv;
        e.busy = busy;
        e.err  = err;
        e.code = code[1:0];
        e.sum  = sum[11:0];
        return e;
    endfunction

    task automatic cmp(input string tag, input string field, input logic [15:0] obs,
                       input logic [15:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
        end
    endtask

    task automatic check_u(input exp_t e);
        cmp(e.tag, "range",        {8'h0, bus_u.range},        {8'h0, e.rng});
        cmp(e.tag, "min_out",      {8'h0, bus_u.min_out},      {8'h0, e.mn});
        cmp(e.tag, "max_out",      {8'h0, bus_u.max_out},      {8'h0, e.mx});
        cmp(e.tag, "count",        {12'h0, bus_u.count},       {12'h0, e.cnt});
        cmp(e.tag, "result_valid", {15'h0, bus_u.result_valid}, {15'h0, e.rv});
        cmp(e.tag, "busy",         {15'h0, bus_u.busy},        {15'h0, e.busy});
        cmp(e.tag, "error",        {15'h0, bus_u.error},       {15'h0, e.err});
        cmp(e.tag, "err_code",     {14'h0, bus_u.err_code},    {14'h0, e.code});
`ifdef RANGE_SUM_EN
        cmp(e.tag, "sum",          {4'h0, bus_u.sum},          {4'h0, e.sum});
`endif
    endtask

    task automatic check_s(input exp_t e);
        cmp(e.tag, "range",        {8'h0, bus_s.range},        {8'h0, e.rng});
        cmp(e.tag, "min_out",      {8'h0, bus_s.min_out},      {8'h0, e.mn});
        cmp(e.tag, "max_out",      {8'h0, bus_s.max_out},      {8'h0, e.mx});
        cmp(e.tag, "count",        {12'h0, bus_s.count},       {12'h0, e.cnt});
        cmp(e.tag, "result_valid", {15'h0, bus_s.result_valid}, {15'h0, e.rv});
        cmp(e.tag, "busy",         {15'h0, bus_s.busy},        {15'h0, e.busy});
        cmp(e.tag, "error",        {15'h0, bus_s.error},       {15'h0, e.err});
        cmp(e.tag, "err_code",     {14'h0, bus_s.err_code},    {14'h0, e.code});
`ifdef RANGE_SUM_EN
        cmp(e.tag, "sum",          {4'h0, bus_s.sum},          {4'h0, e.sum});
`endif
    endtask

    // One clock of stimulus on the unsigned instance; checks the queued snapshot if any
    task automatic step_u(input logic g, input logic f, input logic dv, input logic [7:0] d);
        @(negedge clock);
        bus_u.go = g; bus_u.finish = f; bus_u.data_valid = dv; bus_u.data_in = d;
        @(posedge clock);
        #1;
        if (sb_u.size() > 0) begin
            exp_t e;
            e = sb_u.pop_front();
            $display("[TB] u %s go=%0b fin=%0b dv=%0b d=%0d", e.tag, g, f, dv, d);
            check_u(e);
        end
        bus_u.go = 1'b0; bus_u.finish = 1'b0; bus_u.data_valid = 1'b0; bus_u.data_in = 8'h00;
    endtask

    task automatic step_s(input logic g, input logic f, input logic dv, input logic [7:0] d);
        @(negedge clock);
        bus_s.go = g; bus_s.finish = f; bus_s.data_valid = dv; bus_s.data_in = d;
        @(posedge clock);
        #1;
        if (sb_s.size() > 0) begin
            exp_t e;
            e = sb_s.pop_front();
            $display("[TB] s %s go=%0b fin=%0b dv=%0b d=%0h", e.tag, g, f, dv, d);
            check_s(e);
        end
        bus_s.go = 1'b0; bus_s.finish = 1'b0; bus_s.data_valid = 1'b0; bus_s.data_in = 8'h00;
    endtask

    initial begin
        bus_u.go = 1'b0; bus_u.finish = 1'b0; bus_u.data_valid = 1'b0; bus_u.data_in = 8'h00;
        bus_s.go = 1'b0; bus_s.finish = 1'b0; bus_s.data_valid = 1'b0; bus_s.data_in = 8'h00;

        // reset state
        sb_u.push_back(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step_u(1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clock);
        reset = 1'b0;

        // go&finish in IDLE, then recovery with a single-sample frame
        sb_u.push_back(mk("t3_gofin", 0, 0, 0, 0, 0, 0, 1, 1, 0));
        step_u(1'b1, 1'b1, 1'b1, 8'd9);
        sb_u.push_back(mk("t3_go", 0, 0, 0, 0, 0, 1, 0, 0, 0));
        step_u(1'b1, 1'b0, 1'b1, 8'd9);
        sb_u.push_back(mk("t3_done", 0, 9, 9, 1, 1, 0, 0, 0, 9));
        step_u(1'b0, 1'b1, 1'b0, 8'd0);

        // basic frame 10,3,(invalid 1),25,7,12
        sb_u.push_back(mk("t1_go", 0, 9, 9, 1, 0, 1, 0, 0, 9));
        step_u(1'b1, 1'b0, 1'b1, 8'd10);
        step_u(1'b0, 1'b0, 1'b1, 8'd3);
        step_u(1'b0, 1'b0, 1'b0, 8'd1);
        step_u(1'b0, 1'b0, 1'b1, 8'd25);
        sb_u.push_back(mk("t1_pre", 0, 9, 9, 1, 0, 1, 0, 0, 9));
        step_u(1'b0, 1'b0, 1'b1, 8'd7);
        sb_u.push_back(mk("t1_done", 22, 3, 25, 5, 1, 0, 0, 0, 57));
        step_u(1'b0, 1'b1, 1'b1, 8'd12);

        // finish in DONE, empty frame, ERROR holds
        sb_u.push_back(mk("t4_fin_done", 22, 3, 25, 5, 0, 0, 1, 2, 57));
        step_u(1'b0, 1'b1, 1'b0, 8'd0);
        sb_u.push_back(mk("t4_go_empty", 22, 3, 25, 5, 0, 1, 0, 0, 57));
        step_u(1'b1, 1'b0, 1'b0, 8'd0);
        sb_u.push_back(mk("t4_empty", 22, 3, 25, 5, 0, 0, 1, 3, 57));
        step_u(1'b0, 1'b1, 1'b0, 8'd0);
        sb_u.push_back(mk("err_fin_hold", 22, 3, 25, 5, 0, 0, 1, 3, 57));
        step_u(1'b0, 1'b1, 1'b1, 8'd4);
        sb_u.push_back(mk("err_gofin_hold", 22, 3, 25, 5, 0, 0, 1, 3, 57));
        step_u(1'b1, 1'b1, 1'b1, 8'd5);

        // leave ERROR; unsigned ordering with a top-half value
        sb_u.push_back(mk("t7_go", 22, 3, 25, 5, 0, 1, 0, 0, 57));
        step_u(1'b1, 1'b0, 1'b1, 8'd5);
        step_u(1'b0, 1'b0, 1'b1, 8'd200);
        sb_u.push_back(mk("t7_done", 195, 5, 200, 2, 1, 0, 0, 0, 205));
        step_u(1'b0, 1'b1, 1'b0, 8'd0);

        // 20 samples of 1: count saturates at 15
        step_u(1'b1, 1'b0, 1'b1, 8'd1);
        for (int i = 0; i < 18; i++) step_u(1'b0, 1'b0, 1'b1, 8'd1);
        sb_u.push_back(mk("t5_sat", 0, 1, 1, 15, 1, 0, 0, 0, 20));
        step_u(1'b0, 1'b1, 1'b1, 8'd1);

        // reset mid-frame after three samples acts without a clock edge
        step_u(1'b1, 1'b0, 1'b1, 8'd50);
        step_u(1'b0, 1'b0, 1'b1, 8'd60);
        step_u(1'b0, 1'b0, 1'b1, 8'd70);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        $display("[TB] u t6_async_reset");
        check_u(mk("t6_async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        reset = 1'b0;

        // restart inside RECEIVING resets the count
        sb_u.push_back(mk("t6_go", 0, 0, 0, 0, 0, 1, 0, 0, 0));
        step_u(1'b1, 1'b0, 1'b1, 8'd40);
        step_u(1'b0, 1'b0, 1'b1, 8'd45);
        sb_u.push_back(mk("t6_restart", 0, 0, 0, 0, 0, 1, 0, 0, 0));
        step_u(1'b1, 1'b0, 1'b1, 8'd30);
        step_u(1'b0, 1'b0, 1'b1, 8'd35);
        sb_u.push_back(mk("t6_done", 5, 30, 35, 3, 1, 0, 0, 0, 98));
        step_u(1'b0, 1'b1, 1'b1, 8'd33);

        // signed instance: -5, 4, -100
        sb_s.push_back(mk("t2_go", 0, 0, 0, 0, 0, 1, 0, 0, 0));
        step_s(1'b1, 1'b0, 1'b1, 8'hFB);
        step_s(1'b0, 1'b0, 1'b1, 8'h04);
        sb_s.push_back(mk("t2_done", 104, 'h9C, 'h04, 3, 1, 0, 0, 0, 'hF9B));
        step_s(1'b0, 1'b1, 1'b1, 8'h9C);

        // signed extremes -128 and 127: range 255 without wrap
        step_s(1'b1, 1'b0, 1'b1, 8'h80);
        sb_s.push_back(mk("t2_extreme", 255, 'h80, 'h7F, 2, 1, 0, 0, 0, 'hFFF));
        step_s(1'b0, 1'b1, 1'b1, 8'h7F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
